// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO bus: register offsets, STATUS bit layout and reset values.
package mmio_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CYCLE  = 4'h8;
    localparam logic [3:0] OFF_HALT   = 4'hC;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 3;
    localparam int STAT_COUNT_W   = 5;

    localparam logic        RST_OVERFLOW  = 1'b0;
    localparam logic        RST_HALT      = 1'b0;
    localparam logic [31:0] RST_HALT_CODE = 32'h0;
    localparam logic [31:0] RST_CYCLE     = 32'h0;

    function automatic logic [31:0] status_word(input logic empty, input logic full,
                                                input logic ovf,
                                                input logic [STAT_COUNT_W-1:0] count);
        logic [31:0] w;
        w = '0;
        w[STAT_EMPTY_BIT] = empty;
        w[STAT_FULL_BIT]  = full;
        w[STAT_OVF_BIT]   = ovf;
        w[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
        return w;
    endfunction

endpackage

// File: rtl/mmio_bus_sync_fifo.sv
// Small flop-based FIFO (module sync_fifo); head is visible combinationally, no write-to-read bypass.
module sync_fifo
    import mmio_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] entries [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign head    = entries[rd_ptr_reg];
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when a pop frees a slot on the same edge.
    assign do_push = push && (!full || do_pop);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (do_push && wr_ptr_reg == PTR_W'(gi))
                    entry_reg <= push_data;
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mmio_bus.sv
// Core-side bus splitter: RAM pass-through plus a 16-byte MMIO window (TX FIFO, STATUS, CYCLE, HALT).
// Define MMIO_CYCLE_CNT_EN to build the free-running CYCLE counter; otherwise CYCLE reads 0.
module mmio_bus
    import mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] halt_code
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             is_mmio, mmio_we;
    logic [3:0]       offset;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow_reg, overflow_set, overflow_clr;
    logic             halt_reg, halt_wr;
    logic [31:0]      halt_code_reg;
    logic [31:0]      cycle_value;

    assign is_mmio   = (core_addr[31:4] == MMIO_BASE[31:4]);
    assign offset    = core_addr[3:0];
    assign mmio_we   = core_we && is_mmio;
    assign mem_we    = core_we && !is_mmio;
    assign mem_addr  = core_addr;
    assign mem_wdata = core_wdata;

    assign fifo_push = mmio_we && (offset == OFF_TXDATA);
    assign fifo_pop  = tx_valid && tx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data (core_wdata[7:0]),
        .pop       (fifo_pop),
        .head      (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_valid     = !fifo_empty;
    assign overflow_set = fifo_push && fifo_full && !fifo_pop;
    assign overflow_clr = mmio_we && (offset == OFF_STATUS) && core_wdata[STAT_OVF_BIT];
    assign halt_wr      = mmio_we && (offset == OFF_HALT) && !halt_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_reg  <= RST_OVERFLOW;
            halt_reg      <= RST_HALT;
            halt_code_reg <= RST_HALT_CODE;
        end else begin
            if (overflow_set)      overflow_reg <= 1'b1;
            else if (overflow_clr) overflow_reg <= 1'b0;
            // Only the first HALT write after reset is captured.
            if (halt_wr) begin
                halt_reg      <= 1'b1;
                halt_code_reg <= core_wdata;
            end
        end
    end

    assign halt      = halt_reg;
    assign halt_code = halt_code_reg;

`ifdef MMIO_CYCLE_CNT_EN
    logic [31:0] cycle_reg;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cycle_reg <= RST_CYCLE;
        else         cycle_reg <= cycle_reg + 32'd1;
    end
    assign cycle_value = cycle_reg;
`else
    assign cycle_value = RST_CYCLE;
`endif

    always_comb begin
        core_rdata = mem_rdata;
        if (is_mmio) begin
            case (offset)
                OFF_STATUS: core_rdata = status_word(fifo_empty, fifo_full, overflow_reg,
                                                     STAT_COUNT_W'(fifo_count));
                OFF_CYCLE:  core_rdata = cycle_value;
                OFF_HALT:   core_rdata = halt_code_reg;
                default:    core_rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bus.sv
// Directed, table-driven bench for mmio_bus (FIFO_DEPTH=4) with hand sequences for CYCLE and reset.
module tb_mmio_bus;

    localparam logic [31:0] MB = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        core_we = 1'b0;
    logic [31:0] core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic [31:0] core_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        halt;
    logic [31:0] halt_code;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmio_bus #(
        .FIFO_DEPTH (4),
        .MMIO_BASE  (MB)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .halt       (halt),
        .halt_code  (halt_code)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic        rdy;
        logic [31:0] exp_rdata;
        logic        exp_mem_we;
        logic        exp_tv;
        logic [7:0]  exp_td;
        logic        exp_halt;
        logic [31:0] exp_hc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] mrd, input logic rdy, input logic [31:0] erd,
                       input logic emwe, input logic etv, input logic [7:0] etd,
                       input logic eh, input logic [31:0] ehc);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.mrd = mrd; v.rdy = rdy;
        v.exp_rdata = erd; v.exp_mem_we = emwe; v.exp_tv = etv; v.exp_td = etd;
        v.exp_halt = eh; v.exp_hc = ehc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        core_we = 1'b1; core_addr = addr; core_wdata = wdata;
        @(posedge clk);
        #1 core_we = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_cycle;

        // Build the vector table: one record per bus cycle, state carried between records.
        //   we  addr     wdata         mrd           rdy  rdata         mwe tv td     h  hc
        add(0, MB+4,  32'h0,        32'h0,        0, 32'h01,       0, 0, 8'h00, 0, 32'h0);
        add(1, MB,    32'h55,       32'h0,        0, 32'h0,        0, 0, 8'h00, 0, 32'h0);
        add(0, MB+4,  32'h0,        32'h0,        0, 32'h08,       0, 1, 8'h55, 0, 32'h0);
        add(1, MB,    32'h66,       32'h0,        0, 32'h0,        0, 1, 8'h55, 0, 32'h0);
        add(1, MB,    32'h77,       32'h0,        0, 32'h0,        0, 1, 8'h55, 0, 32'h0);
        add(1, MB,    32'h88,       32'h0,        0, 32'h0,        0, 1, 8'h55, 0, 32'h0);
        add(0, MB+4,  32'h0,        32'h0,        0, 32'h22,       0, 1, 8'h55, 0, 32'h0);
        add(1, MB,    32'h99,       32'h0,        0, 32'h0,        0, 1, 8'h55, 0, 32'h0);
        add(0, MB+4,  32'h0,        32'h0,        0, 32'h26,       0, 1, 8'h55, 0, 32'h0);
        add(1, MB+4,  32'h4,        32'h0,        0, 32'h26,       0, 1, 8'h55, 0, 32'h0);
        add(0, MB+4,  32'h0,        32'h0,        0, 32'h22,       0, 1, 8'h55, 0, 32'h0);
        add(1, MB,    32'hAA,       32'h0,        1, 32'h0,        0, 1, 8'h55, 0, 32'h0);
        add(0, MB+4,  32'h0,        32'h0,        0, 32'h22,       0, 1, 8'h66, 0, 32'h0);
        add(0, MB+4,  32'h0,        32'h0,        1, 32'h22,       0, 1, 8'h66, 0, 32'h0);
        add(0, MB+4,  32'h0,        32'h0,        1, 32'h18,       0, 1, 8'h77, 0, 32'h0);
        add(0, MB+4,  32'h0,        32'h0,        1, 32'h10,       0, 1, 8'h88, 0, 32'h0);
        add(0, MB+4,  32'h0,        32'h0,        1, 32'h08,       0, 1, 8'hAA, 0, 32'h0);
        add(0, MB+4,  32'h0,        32'h0,        0, 32'h01,       0, 0, 8'h00, 0, 32'h0);
        add(0, MB+12, 32'h0,        32'h0,        0, 32'h0,        0, 0, 8'h00, 0, 32'h0);
        add(1, MB+12, 32'h1234,     32'h0,        0, 32'h0,        0, 0, 8'h00, 0, 32'h0);
        add(1, MB+12, 32'h9999,     32'h0,        0, 32'h1234,     0, 0, 8'h00, 1, 32'h1234);
        add(0, MB+12, 32'h0,        32'h0,        0, 32'h1234,     0, 0, 8'h00, 1, 32'h1234);
        add(1, 32'h100, 32'hDEAD,   32'hCAFEF00D, 0, 32'hCAFEF00D, 1, 0, 8'h00, 1, 32'h1234);
        add(1, MB+16, 32'h55,       32'h1111,     0, 32'h1111,     1, 0, 8'h00, 1, 32'h1234);
        add(0, MB+4,  32'h0,        32'h0,        0, 32'h01,       0, 0, 8'h00, 1, 32'h1234);
        add(0, MB+1,  32'h0,        32'h2222,     0, 32'h0,        0, 0, 8'h00, 1, 32'h1234);

        // Reset state while resetn is low; RAM path must still follow the core.
        core_addr = 32'h0000_0200; core_wdata = 32'h1357;
        #2 resetn = 1'b0;
        #1;
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_halt", {31'b0, halt}, 32'h0);
        check("rst_halt_code", halt_code, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h200);
        check("rst_mem_wdata", mem_wdata, 32'h1357);
        $display("reset: tx_valid=%0b halt=%0b halt_code=0x%08h", tx_valid, halt, halt_code);

        // CYCLE after exactly 10 edges out of reset.
        core_addr = MB + 8;
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
`ifdef MMIO_CYCLE_CNT_EN
        exp_cycle = 32'd10;
`else
        exp_cycle = 32'd0;
`endif
        check("cycle_after_10", core_rdata, exp_cycle);
        $display("cycle: read 0x%08h expected 0x%08h", core_rdata, exp_cycle);

        foreach (vecs[i]) begin
            @(negedge clk);
            core_we = vecs[i].we; core_addr = vecs[i].addr; core_wdata = vecs[i].wdata;
            mem_rdata = vecs[i].mrd; tx_ready = vecs[i].rdy;
            #1;
            check($sformatf("v%0d_rdata", i), core_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].exp_mem_we});
            check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].addr);
            check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].wdata);
            check($sformatf("v%0d_tx_valid", i), {31'b0, tx_valid}, {31'b0, vecs[i].exp_tv});
            if (vecs[i].exp_tv)
                check($sformatf("v%0d_tx_data", i), {24'b0, tx_data}, {24'b0, vecs[i].exp_td});
            check($sformatf("v%0d_halt", i), {31'b0, halt}, {31'b0, vecs[i].exp_halt});
            check($sformatf("v%0d_halt_code", i), halt_code, vecs[i].exp_hc);
            $display("vec %0d: we=%0b addr=0x%08h wdata=0x%08h rdy=%0b -> rdata=0x%08h tv=%0b td=0x%02h halt=%0b",
                     i, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdy,
                     core_rdata, tx_valid, tx_data, halt);
        end

        // Reset mid-transfer with three bytes queued and halt set.
        @(negedge clk);
        core_we = 1'b0; tx_ready = 1'b0; mem_rdata = '0;
        do_write(MB, 32'h01);
        do_write(MB, 32'h02);
        do_write(MB, 32'h03);
        @(negedge clk);
        core_addr = MB + 4;
        #1 check("pre_rst_status", core_rdata, 32'h18);
        #1 resetn = 1'b0;
        #1;
        check("midrst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("midrst_halt", {31'b0, halt}, 32'h0);
        check("midrst_halt_code", halt_code, 32'h0);
        $display("mid-transfer reset: tx_valid=%0b halt=%0b", tx_valid, halt);
        @(negedge clk);
        resetn = 1'b1;
        #1 check("post_rst_status", core_rdata, 32'h01);
        $display("after release: STATUS=0x%08h", core_rdata);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_bus.md
MMIO_BUS -- requirements
Module: mmio_bus

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning TX FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter MMIO_BASE, default 32'h1000_0000, meaning base address of the peripheral window.
REQ-003 SHALL have reset resetn, asynchronous, active-low, and clock clk.
REQ-004 SHALL list ports, clock and reset first:
- clk  in  1  system clock.
- resetn  in  1  async active-low reset.
- core_we  in  1  core write strobe.
- core_addr  in  32  core byte address.
- core_wdata  in  32  core write data.
- core_rdata  out  32  read data returned to the core.
- mem_we  out  1  RAM write strobe.
- mem_addr  out  32  RAM address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, combinational.
- tx_valid  out  1  TX byte available.
- tx_data  out  8  TX byte, FIFO head.
- tx_ready  in  1  sink accepts byte.
- halt  out  1  sticky halt request.
- halt_code  out  32  value written to HALT.

Function
REQ-005 SHALL decode core_addr[31:4]==MMIO_BASE[31:4] as the MMIO window and every other address as RAM.
REQ-006 SHALL pass RAM accesses through combinationally: mem_addr=core_addr and mem_wdata=core_wdata always; mem_we=core_we only for RAM addresses.
REQ-007 SHALL drive core_rdata combinationally in the same cycle as core_addr: mem_rdata for RAM, register value for MMIO, zero for unmapped MMIO offsets.
REQ-008 SHALL implement MMIO offsets:
- 0x0 TXDATA (W): push core_wdata[7:0]; reads return 0.
- 0x4 STATUS (R): bit0 empty, bit1 full, bit2 overflow, bits[7:3] count; writing 1 to bit2 clears overflow.
- 0x8 CYCLE (R): free-running counter; writes ignored.
- 0xC HALT (W): sets halt; reads return halt_code.
REQ-009 SHALL apply MMIO writes on the rising clk edge where core_we=1; the effect SHALL be visible to a read on the following cycle.
REQ-010 SHALL drive tx_valid=!empty and tx_data=FIFO head; a byte SHALL pop on an edge where tx_valid&&tx_ready.
REQ-011 SHALL NOT bypass: a push into an empty FIFO raises tx_valid on the next cycle.
REQ-012 SHALL drop a push when the FIFO is full with no pop in that cycle, and SHALL set overflow, which stays set until cleared or reset.
REQ-013 SHALL accept a push when full if a pop occurs in the same cycle; count stays FIFO_DEPTH.
REQ-014 SHALL give priority to a set over a clear when an overflow-setting push and a STATUS clear write coincide; as both come from one core write, this is unreachable and is stated for completeness.
REQ-015 SHALL wrap read/write pointers modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-016 SHALL increment CYCLE every clk after reset and wrap from 32'hFFFF_FFFF to 0.
REQ-017 SHALL latch halt_code from core_wdata and set halt on the first HALT write only; later HALT writes SHALL be ignored until reset.

Reset
REQ-018 SHALL on resetn=0, at any time including mid-transfer, empty the FIFO, clear pointers, overflow, CYCLE, halt and halt_code to 0.
REQ-019 SHALL hold tx_valid=0, halt=0 and halt_code=0 during reset; combinational outputs SHALL follow their inputs.

Configuration
REQ-020 SHALL include the CYCLE counter only when macro MMIO_CYCLE_CNT_EN is defined; without the macro, CYCLE SHALL read 0 and no counter flops SHALL exist.

Structure
REQ-021 SHALL place MMIO offsets, STATUS bit positions and the reset value constants in package mmio_pkg.
REQ-022 SHALL implement the TX buffer as sub-module sync_fifo, parameterised on width 8 and FIFO_DEPTH, with push, pop, full, empty and count.

Verification
REQ-023 Write 0x55 to 0x0 with tx_ready=0 -> next cycle tx_valid=1, tx_data=0x55, STATUS=0x08.
REQ-024 Push 5 bytes with FIFO_DEPTH=4 and tx_ready=0 -> 5th byte dropped, STATUS=0x26; write 0x4 to STATUS -> STATUS=0x22.
REQ-025 Fill the FIFO, then push 0xAA with tx_ready=1 in the same cycle -> head popped, 0xAA accepted, overflow=0, count=4.
REQ-026 Write 0x1234 then 0x9999 to HALT -> halt=1, halt_code=0x1234; RAM write to 0x100 -> mem_we=1, no MMIO effect.
REQ-027 With MMIO_CYCLE_CNT_EN defined, 10 cycles after reset -> CYCLE reads 10; without the macro -> CYCLE reads 0.
REQ-028 Assert resetn=0 with 3 bytes queued -> tx_valid=0 immediately, STATUS=0x01 after release.
